risc_ctrl_fsm: RTL and testbench
================================

# risc_ctrl_fsm

Parametrised multicycle control unit for the RISC processor. It replaces the fixed 16-bit control path with a handshake-aware sequencer that generalises data width, stalls on a memory-ready signal, detects memory timeouts and illegal opcodes, and counts retired instructions. It sits between the instruction register / datapath flags and the datapath control inputs, alongside the datapath inside the processor top.

## Interface
- DATA_W, 16: width of the `outA` operand used for the zero test.
- OP_W, 4: opcode width. Values 0–15 decode as listed below; any higher value is illegal.
- MAX_WAIT, 15: maximum cycles spent in any wait state before a bus error. Must be ≥ 1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- opcode  in  OP_W  IR opcode field.
- outA  in  DATA_W  register A read data, used for the zero test.
- carry  in  1  ALU carry flag.
- mem_ready  in  1  memory completes the current re/we access.
- pc_sel, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel  out  1  datapath controls.
- data_sel  out  2  write-back source: 0 = ALU, 1 = memory.
- opb_sel  out  2  B operand: 0 = register B, 1 = immediate.
- alu_sel  out  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- re, we  out  1  memory read and write strobes.
- halted  out  1  core stopped.
- err  out  1  stop caused by an illegal opcode or a timeout.
- retired  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 ADDI
  - 7 LD, 8 ST
  - 9 BEQZ (taken when outA == 0)
  - 10 BC (taken when carry = 1)
  - 11 JMP
  - 15 HLT
  - 12–14 illegal
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drives re = 1 and addr_sel = 0.
  - On mem_ready: ir_wrt = 1, pc_wrt = 1, pc_sel = 0 (PC+1), then go to DECODE.
- DECODE:
  - NOP → FETCH; retires.
  - HLT → HALT; retires.
  - Illegal opcode → HALT with err = 1.
  - All other opcodes → EXEC.
- EXEC:
  - ALU ops and ADDI: drive alu_sel; opb_sel = 1 for ADDI; → WB.
  - LD/ST: alu_sel = ADD, opb_sel = 1 to form the address; → MEM.
  - Branches: pc_sel = 1; pc_wrt = 1 only if taken (JMP is always taken); → FETCH; retires.
- MEM:
  - addr_sel = 1, with re = 1 for LD or we = 1 for ST. Waits for mem_ready.
  - LD → WB.
  - ST → FETCH; retires.
- WB: reg_wrt = 1; data_sel = 1 for LD, 0 otherwise; → FETCH; retires.
- HALT is sticky until reset; all strobes are 0 and halted = 1.
- Wait timer:
  - Clears on entry to FETCH or MEM and increments each cycle while mem_ready = 0.
  - When the count reaches MAX_WAIT with mem_ready still 0 → HALT with err = 1.
  - mem_ready in the same cycle as the limit counts as success.
- Outputs are decoded combinationally from state, opcode and flags. mem_ready gates only ir_wrt and pc_wrt in FETCH.

## Timing
- While reset is low:
  - All outputs are 0, and retired is 0.
  - The state moves to FETCH on the edge where reset is sampled low.
  - Reset mid-access abandons the access; re/we drop in the following cycle.
- Cycles per instruction with zero-wait memory (mem_ready held high):
  - NOP 2; branches 3; ALU/ADDI 4; ST 4; LD 5.
  - Each wait cycle adds 1.
- retired increments on the edge that leaves the retiring state.
- re/we stay asserted until mem_ready is sampled high. Memory must treat them as level requests.
- Flags (outA, carry) are sampled in EXEC only.

## Structure
- Shared package risc_pkg holds:
  - opcode constants;
  - alu_sel and data_sel encodings;
  - the state enum.
- Sub-module risc_wait_timer holds the parametrised wait counter with clear, enable and expired outputs.

## Test plan
- ADD with mem_ready held high → reg_wrt in the 4th cycle after FETCH; retired goes 0→1.
- LD with mem_ready low for 3 cycles in MEM → total latency 8 cycles; data_sel = 1 in WB.
- BEQZ with outA = 0 → pc_wrt = 1, pc_sel = 1 in EXEC. With outA = 5 → pc_wrt = 0.
- Opcode 13 → halted = 1, err = 1 after DECODE; stays halted for 20 cycles; retired unchanged.
- MAX_WAIT = 4 with mem_ready never asserted in FETCH → err = 1 after 4 wait cycles.
- reset low during MEM of ST → we = 0 the next cycle; FETCH on release; retired = 0.

Source files
------------

// File: rtl/risc_pkg.sv
// risc_pkg: shared constants for the RISC multicycle control path.
//   - opcode constants (4-bit field values; wider opcodes above 15 are illegal)
//   - alu_sel, opb_sel and data_sel encodings
//   - control FSM state enum
package risc_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_BEQZ = 4'd9;
  localparam logic [3:0] OP_BC   = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] OPB_REG = 2'd0;
  localparam logic [1:0] OPB_IMM = 2'd1;

  localparam logic [1:0] DSEL_ALU = 2'd0;
  localparam logic [1:0] DSEL_MEM = 2'd1;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/risc_wait_timer.sv
// risc_wait_timer: counts consecutive wait cycles of a memory access.
//   clk, reset (sync, active-low)
//   clr     : restart the count (state transition)
//   en      : this cycle is a wait cycle (access pending, mem_ready low)
//   expired : this wait cycle is the MAX_WAIT-th one
module risc_wait_timer
  import risc_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of wait cycles already spent, so the current
  // wait cycle is the last allowed one when cnt_q == MAX_WAIT-1.
  assign expired = en && (cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// risc_ctrl_fsm: multicycle control sequencer for the RISC core.
//   Inputs : opcode (IR field), outA (zero test), carry, mem_ready
//   Outputs: datapath selects/strobes, re/we memory strobes,
//            halted, err (illegal opcode or timeout), retired count
//   All outputs decode combinationally from state, opcode and flags and
//   are forced to 0 while reset is low.
module risc_ctrl_fsm
  import risc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OP_W     = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] outA,
  input  logic              carry,
  input  logic              mem_ready,
  output logic              pc_sel,
  output logic              pc_wrt,
  output logic              addr_sel,
  output logic              ir_wrt,
  output logic              rega_sel,
  output logic              reg_wrt,
  output logic              opa_sel,
  output logic [1:0]        data_sel,
  output logic [1:0]        opb_sel,
  output logic [2:0]        alu_sel,
  output logic              re,
  output logic              we,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               ret_inc, err_set, expired, wait_en;
  logic [3:0]         op4;
  logic               op_legal, is_ld, is_st;

  assign op4      = opcode[3:0];
  assign op_legal = (opcode <= OP_W'(15)) && !(op4 inside {4'd12, 4'd13, 4'd14});
  assign is_ld    = (op4 == OP_LD);
  assign is_st    = (op4 == OP_ST);

  // Wait cycles only exist in the two states that hold a memory access.
  assign wait_en = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;

  risc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_d != state_q),
    .en      (wait_en),
    .expired (expired)
  );

  always_comb begin
    state_d  = state_q;
    ret_inc  = 1'b0;
    err_set  = 1'b0;
    pc_sel   = 1'b0;
    pc_wrt   = 1'b0;
    addr_sel = 1'b0;
    ir_wrt   = 1'b0;
    rega_sel = 1'b0;
    reg_wrt  = 1'b0;
    opa_sel  = 1'b0;
    data_sel = DSEL_ALU;
    opb_sel  = OPB_REG;
    alu_sel  = ALU_ADD;
    re       = 1'b0;
    we       = 1'b0;
    halted   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        re = 1'b1;
        if (mem_ready) begin
          ir_wrt  = 1'b1;
          pc_wrt  = 1'b1;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!op_legal) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end else if (op4 == OP_NOP) begin
          state_d = ST_FETCH;
          ret_inc = 1'b1;
        end else if (op4 == OP_HLT) begin
          state_d = ST_HALT;
          ret_inc = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
        case (op4)
          OP_ADD:  alu_sel = ALU_ADD;
          OP_SUB:  alu_sel = ALU_SUB;
          OP_AND:  alu_sel = ALU_AND;
          OP_OR:   alu_sel = ALU_OR;
          OP_XOR:  alu_sel = ALU_XOR;
          OP_ADDI: opb_sel = OPB_IMM;
          OP_LD, OP_ST: begin
            opb_sel = OPB_IMM;
            state_d = ST_MEM;
          end
          OP_BEQZ, OP_BC, OP_JMP: begin
            pc_sel  = 1'b1;
            pc_wrt  = (op4 == OP_JMP) || ((op4 == OP_BEQZ) && (outA == '0)) ||
                      ((op4 == OP_BC) && carry);
            state_d = ST_FETCH;
            ret_inc = 1'b1;
          end
          default: begin
            // Opcode changed under us after DECODE; treat as illegal.
            state_d = ST_HALT;
            err_set = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        re       = is_ld;
        we       = is_st;
        if (mem_ready) begin
          state_d = is_ld ? ST_WB : ST_FETCH;
          ret_inc = !is_ld;
        end else if (expired) begin
          state_d = ST_HALT;
          err_set = 1'b1;
        end
      end
      ST_WB: begin
        reg_wrt  = 1'b1;
        data_sel = is_ld ? DSEL_MEM : DSEL_ALU;
        state_d  = ST_FETCH;
        ret_inc  = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_HALT;
    endcase
    if (!reset) begin
      pc_sel   = 1'b0;
      pc_wrt   = 1'b0;
      addr_sel = 1'b0;
      ir_wrt   = 1'b0;
      reg_wrt  = 1'b0;
      data_sel = DSEL_ALU;
      opb_sel  = OPB_REG;
      alu_sel  = ALU_ADD;
      re       = 1'b0;
      we       = 1'b0;
      halted   = 1'b0;
    end
  end

  assign err_d     = err_q | err_set;
  assign retired_d = retired_q + CNT_W'(ret_inc);
  assign err       = err_q & reset;
  assign retired   = reset ? retired_q : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      err_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
module tb_risc_ctrl_fsm;
  localparam int DW = 16, OW = 4, MW = 4, CW = 16;

  logic clk = 1'b0, reset = 1'b0, carry = 1'b0, mem_ready = 1'b0;
  logic [OW-1:0] opcode = '0;
  logic [DW-1:0] outA = '0;
  logic pc_sel, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel, re, we, halted, err;
  logic [1:0] data_sel, opb_sel;
  logic [2:0] alu_sel;
  logic [CW-1:0] retired;

  int checks = 0, failures = 0, exp_ret = 0;

  risc_ctrl_fsm #(.DATA_W(DW), .OP_W(OW), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .outA(outA), .carry(carry),
    .mem_ready(mem_ready), .pc_sel(pc_sel), .pc_wrt(pc_wrt), .addr_sel(addr_sel),
    .ir_wrt(ir_wrt), .rega_sel(rega_sel), .reg_wrt(reg_wrt), .opa_sel(opa_sel),
    .data_sel(data_sel), .opb_sel(opb_sel), .alu_sel(alu_sel), .re(re), .we(we),
    .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [17:0] act = {pc_sel, pc_wrt, addr_sel, ir_wrt, rega_sel, reg_wrt, opa_sel,
                     data_sel, opb_sel, alu_sel, re, we, halted, err};

  // Expected control word; rega_sel/opa_sel are never driven by this sequencer.
  function automatic logic [17:0] ev(bit ps = 0, bit pw = 0, bit as = 0, bit iw = 0,
                                     bit rw = 0, logic [1:0] ds = 0, logic [1:0] ob = 0,
                                     logic [2:0] al = 0, bit r = 0, bit w = 0,
                                     bit h = 0, bit e = 0);
    return {ps, pw, as, iw, 1'b0, rw, 1'b0, ds, ob, al, r, w, h, e};
  endfunction

  // Inputs are set before the call; outputs sampled at negedge, then one edge.
  task automatic chk(string tag, logic [17:0] exp);
    @(negedge clk);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s ctl observed=%h expected=%h", tag, act, exp);
    end
    checks++;
    assert (retired === CW'(exp_ret)) else begin
      failures++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, retired, exp_ret);
    end
    @(posedge clk); #1;
  endtask

  task automatic halt_chk(int n, bit e);
    repeat (n) begin
      mem_ready = 1'($urandom);
      chk("halt", ev(.h(1), .e(e)));
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    exp_ret = 0;
    repeat (2) begin
      mem_ready = 1'($urandom);
      chk("reset", '0);
    end
    reset = 1'b1;
  endtask

  // One instruction from FETCH, following the instruction-level rules:
  // fw/mw = wait cycles before mem_ready in FETCH / MEM.
  task automatic run(int op, int fw, int mw, logic [DW-1:0] a, bit c, bit rst_mem);
    bit ld, st, taken;
    opcode = OW'(op); outA = a; carry = c;
    for (int i = 0; i < fw && i < MW; i++) begin
      mem_ready = 1'b0;
      chk("fetch_wait", ev(.r(1)));
    end
    if (fw >= MW) begin halt_chk(3, 1); return; end
    mem_ready = 1'b1;
    chk("fetch", ev(.pw(1), .iw(1), .r(1)));
    mem_ready = 1'($urandom);
    chk("decode", '0);
    if (op >= 12 && op <= 14) begin halt_chk(20, 1); return; end
    if (op == 0) begin exp_ret++; return; end
    if (op == 15) begin exp_ret++; halt_chk(3, 0); return; end
    mem_ready = 1'($urandom);
    if (op >= 9) begin
      taken = (op == 11) || (op == 9 && a == 0) || (op == 10 && c);
      chk("exec_br", ev(.ps(1), .pw(taken)));
      exp_ret++;
      return;
    end
    if (op <= 6) begin
      chk("exec_alu", ev(.al(op == 6 ? 3'd0 : 3'(op - 1)), .ob(op == 6 ? 2'd1 : 2'd0)));
      mem_ready = 1'($urandom);
      chk("wb_alu", ev(.rw(1)));
      exp_ret++;
      return;
    end
    ld = (op == 7); st = (op == 8);
    chk("exec_mem", ev(.ob(1)));
    for (int i = 0; i < mw && i < MW; i++) begin
      mem_ready = 1'b0;
      chk("mem_wait", ev(.as(1), .r(ld), .w(st)));
      if (rst_mem) begin
        reset = 1'b0; exp_ret = 0;
        chk("rst_mem", '0);
        chk("rst_mem2", '0);
        reset = 1'b1;
        return;
      end
    end
    if (mw >= MW) begin halt_chk(3, 1); return; end
    mem_ready = 1'b1;
    chk("mem", ev(.as(1), .r(ld), .w(st)));
    if (st) begin exp_ret++; return; end
    mem_ready = 1'($urandom);
    chk("wb_ld", ev(.rw(1), .ds(1)));
    exp_ret++;
  endtask

  initial begin
    // Outputs are forced low while reset is held, even before the first edge.
    chk("reset_pre", '0);
    do_reset();
    run(1, 0, 0, 16'd3, 0, 0);            // ADD zero-wait
    run(7, 0, 3, 16'd1, 0, 0);            // LD with 3 MEM waits
    run(9, 0, 0, 16'd0, 0, 0);            // BEQZ taken
    run(9, 0, 0, 16'd5, 0, 0);            // BEQZ not taken
    run(10, 1, 0, 16'd5, 1, 0);           // BC taken
    run(10, 0, 0, 16'd0, 0, 0);           // BC not taken
    run(8, MW - 1, MW - 1, 16'd2, 0, 0);  // ready on the limit cycle succeeds
    for (int k = 0; k < 40; k++)
      run($urandom_range(0, 11), $urandom_range(0, MW - 1), $urandom_range(0, MW - 1),
          ($urandom_range(0, 1) != 0) ? DW'(0) : DW'($urandom), 1'($urandom), 0);
    run(13, 0, 0, 16'd0, 0, 0);           // illegal opcode, 20 halted cycles
    do_reset();
    run(6, 0, 0, 16'd0, 0, 0);
    run(15, 0, 0, 16'd0, 0, 0);           // HLT retires and halts without err
    do_reset();
    run(2, MW, 0, 16'd0, 0, 0);           // FETCH timeout
    do_reset();
    run(0, 0, 0, 16'd0, 0, 0);
    run(7, 0, MW, 16'd0, 0, 0);           // MEM timeout
    do_reset();
    run(3, 0, 0, 16'd0, 0, 0);
    run(8, 0, 2, 16'd0, 0, 1);            // reset during MEM of ST
    run(11, 0, 0, 16'd0, 0, 0);
    run(5, 2, 0, 16'd0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
